// File: rtl/cipher_serializer.sv
// cipher_serializer: captures a ciphertext block on the rising edge of `done` and
// streams it most-significant beat first over valid/ready, with a one-block pending buffer.
module cipher_serializer #(
   parameter int DATA_W = 128,
   parameter int OUT_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              done,
   input  logic [DATA_W-1:0] cipher,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [OUT_W-1:0]  out_data,
   output logic              out_last,
   output logic              busy,
   output logic              overrun,
   input  logic              ovr_clr
);

   localparam int BEATS = DATA_W / OUT_W;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_e;

   state_e            state_q,    state_d;
   logic [DATA_W-1:0] shreg_q,    shreg_d;
   logic [CNT_W-1:0]  cnt_q,      cnt_d;
   logic [DATA_W-1:0] pend_q,     pend_d;
   logic              pend_v_q,   pend_v_d;
   logic              done_dly_q, done_dly_d;
   logic              ovr_q,      ovr_d;

   logic              cap_s;
   logic              xfer_s;
   logic              last_xfer_s;
   logic              ovr_set_s;

   // Next-state, datapath and overrun logic
   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      cnt_d       = cnt_q;
      pend_d      = pend_q;
      pend_v_d    = pend_v_q;
      done_dly_d  = done;
      ovr_set_s   = 1'b0;
      cap_s       = done & ~done_dly_q;
      xfer_s      = (state_q == ST_SEND) & out_ready;
      last_xfer_s = xfer_s & (cnt_q == LAST_BEAT);

      case (state_q)
         ST_IDLE: begin
            if (cap_s) begin
               shreg_d = cipher;
               cnt_d   = {CNT_W{1'b0}};
               state_d = ST_SEND;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SEND: begin
            if (last_xfer_s) begin
               cnt_d = {CNT_W{1'b0}};
               // The pending block always goes first; a coincident capture refills the buffer.
               if (pend_v_q) begin
                  shreg_d = pend_q;
                  if (cap_s) begin
                     pend_d   = cipher;
                     pend_v_d = 1'b1;
                  end else begin
                     pend_v_d = 1'b0;
                  end
               end else if (cap_s) begin
                  shreg_d = cipher;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               if (xfer_s) begin
                  shreg_d = shreg_q << OUT_W;
                  cnt_d   = cnt_q + CNT_W'(1);
               end else begin
                  shreg_d = shreg_q;
               end
               if (cap_s) begin
                  if (pend_v_q) begin
                     ovr_set_s = 1'b1;
                  end else begin
                     pend_d   = cipher;
                     pend_v_d = 1'b1;
                  end
               end else begin
                  pend_v_d = pend_v_q;
               end
            end
         end
         default: begin
            state_d  = ST_IDLE;
            cnt_d    = {CNT_W{1'b0}};
            pend_v_d = 1'b0;
         end
      endcase

      if (ovr_set_s) begin
         ovr_d = 1'b1;
      end else if (ovr_clr) begin
         ovr_d = 1'b0;
      end else begin
         ovr_d = ovr_q;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         shreg_q    <= {DATA_W{1'b0}};
         cnt_q      <= {CNT_W{1'b0}};
         pend_q     <= {DATA_W{1'b0}};
         pend_v_q   <= 1'b0;
         done_dly_q <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         cnt_q      <= cnt_d;
         pend_q     <= pend_d;
         pend_v_q   <= pend_v_d;
         done_dly_q <= done_dly_d;
         ovr_q      <= ovr_d;
      end
   end

   assign out_valid = (state_q == ST_SEND);
   assign out_data  = shreg_q[DATA_W-1 -: OUT_W];
   assign out_last  = (state_q == ST_SEND) & (cnt_q == LAST_BEAT);
   assign busy      = (state_q == ST_SEND) | pend_v_q;
   assign overrun   = ovr_q;

endmodule

// File: tb/tb_cipher_serializer.sv
// tb_cipher_serializer: directed and randomized stimulus checked against a block-queue
// reference model of the serializer.
module tb_cipher_serializer;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         done = 1'b0;
   logic [127:0] cipher = 128'h0;
   logic         out_ready = 1'b0;
   logic         ovr_clr = 1'b0;
   logic         out_valid;
   logic [7:0]   out_data;
   logic         out_last;
   logic         busy;
   logic         overrun;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: blocks still owed to the sink, front one is being sent.
   logic [127:0] mq[$];
   int           m_idx = 0;
   logic         m_done_d = 1'b0;
   logic         m_ovr = 1'b0;
   int           m_xfers = 0;
   int           dut_xfers = 0;

   localparam logic [127:0] C1 = 128'h3925841D02DC09FBDC118597196A0B32;
   localparam logic [127:0] C2 = 128'h00112233445566778899AABBCCDDEEFF;

   cipher_serializer #(.DATA_W(128), .OUT_W(8)) dut (
      .clk(clk), .reset(reset), .done(done), .cipher(cipher),
      .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
      .out_last(out_last), .busy(busy), .overrun(overrun), .ovr_clr(ovr_clr)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_idx    = 0;
      m_done_d = 1'b0;
      m_ovr    = 1'b0;
   endtask

   function automatic logic [7:0] model_byte();
      logic [127:0] b;
      b = mq[0] >> (8 * (15 - m_idx));
      return b[7:0];
   endfunction

   // Apply the clock-edge rules to the model using the inputs present at the edge.
   task automatic model_edge();
      logic ev;
      logic set;
      if (!reset) begin
         model_reset();
         return;
      end
      ev  = done && !m_done_d;
      set = 1'b0;
      if (mq.size() > 0 && out_ready) begin
         m_xfers++;
         if (m_idx == 15) begin
            void'(mq.pop_front());
            m_idx = 0;
         end else begin
            m_idx++;
         end
      end
      if (ev) begin
         if (mq.size() < 2) mq.push_back(cipher);
         else set = 1'b1;
      end
      m_ovr    = set ? 1'b1 : (ovr_clr ? 1'b0 : m_ovr);
      m_done_d = done;
   endtask

   task automatic compare_outputs();
      check_val("out_valid", 32'(out_valid), 32'(mq.size() > 0));
      check_val("busy", 32'(busy), 32'(mq.size() > 0));
      check_val("overrun", 32'(overrun), 32'(m_ovr));
      if (mq.size() > 0) begin
         check_val("out_data", 32'(out_data), 32'(model_byte()));
         check_val("out_last", 32'(out_last), 32'(m_idx == 15));
      end
   endtask

   task automatic step();
      model_edge();
      if (reset && out_valid && out_ready) dut_xfers++;
      @(posedge clk);
      #1;
      compare_outputs();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic pulse_done(input logic [127:0] c, input int len);
      cipher = c;
      done   = 1'b1;
      run(len);
      done   = 1'b0;
   endtask

   initial begin
      // Reset state
      #12;
      check_val("rst_valid", 32'(out_valid), 32'd0);
      check_val("rst_data", 32'(out_data), 32'd0);
      check_val("rst_last", 32'(out_last), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_ovr", 32'(overrun), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      model_reset();

      // Single block, 3-cycle done, sink always ready
      out_ready = 1'b1;
      pulse_done(C1, 3);
      run(20);
      check_val("single_xfers", 32'(dut_xfers), 32'd16);
      check_val("single_busy", 32'(busy), 32'd0);

      // Backpressure 1,0,0 pattern
      dut_xfers = 0;
      pulse_done(C1, 1);
      for (int i = 0; i < 60; i++) begin
         out_ready = (i % 3 == 0);
         step();
      end
      check_val("bp_xfers", 32'(dut_xfers), 32'd16);

      // Back-to-back: second block captured during beat 5 of the first
      out_ready = 1'b1;
      pulse_done(C1, 1);
      run(5);
      pulse_done(C2, 1);
      run(40);
      check_val("b2b_ovr", 32'(overrun), 32'd0);

      // Overrun: several captures during one block, then clear
      out_ready = 1'b1;
      pulse_done(C1, 1);
      for (int k = 0; k < 3; k++) begin
         run(1);
         pulse_done(C2 ^ 128'(k), 1);
      end
      check_val("ovr_set", 32'(overrun), 32'd1);
      run(40);
      ovr_clr = 1'b1;
      run(1);
      ovr_clr = 1'b0;
      check_val("ovr_clr", 32'(overrun), 32'd0);

      // Asynchronous reset at beat 7
      pulse_done(C2, 1);
      run(7);
      #2;
      reset = 1'b0;
      #1;
      check_val("arst_valid", 32'(out_valid), 32'd0);
      check_val("arst_busy", 32'(busy), 32'd0);
      model_reset();
      run(2);
      reset = 1'b1;
      run(20);

      // Capture coinciding with last-beat transfer, pending empty
      out_ready = 1'b1;
      pulse_done(C1, 1);
      run(15);
      pulse_done(C2, 1);
      check_val("coin_valid", 32'(out_valid), 32'd1);
      check_val("coin_data", 32'(out_data), 32'h00);
      run(20);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         cipher    = {$urandom, $urandom, $urandom, $urandom};
         done      = ($urandom_range(0, 9) < 2);
         out_ready = ($urandom_range(0, 3) != 0);
         ovr_clr   = ($urandom_range(0, 49) == 0);
         step();
      end
      done    = 1'b0;
      ovr_clr = 1'b0;
      out_ready = 1'b1;
      run(40);
      check_val("rand_drained", 32'(busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
